// File: rtl/multiplicador_4bit_seq.sv
// Sequential unsigned shift-and-add multiplier: one conditional add per cycle over WIDTH
// iterations, returning a 2*WIDTH-bit product with a one-cycle done pulse.
module multiplicador_4bit_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   producto,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic [WIDTH-1:0]    mcand_q;
    logic [WIDTH-1:0]    acc_hi_q;
    logic [WIDTH-1:0]    acc_lo_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [WIDTH:0]      sum_d;
    logic [PROD_W-1:0]   acc_d;

    // One iteration: add multiplicand when the current multiplier bit is set, keep the carry,
    // then shift the whole {carry, high, low} vector right by one.
    always_comb begin
        sum_d = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : (WIDTH + 1)'(0));
        acc_d = {sum_d, acc_lo_q[WIDTH-1:1]};
    end

    // Status outputs lag the state by one edge so busy covers exactly the WIDTH iteration cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            producto <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            busy <= (state_q == CALC);
            done <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= A;
                        acc_hi_q <= '0;
                        acc_lo_q <= B;
                        cnt_q    <= '0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_hi_q <= acc_d[PROD_W-1:WIDTH];
                    acc_lo_q <= acc_d[WIDTH-1:0];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        producto <= acc_d;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
